// File: rtl/sys_arr_pkg.sv
// Shared systolic-array parameters.
package sys_arr_pkg;
  localparam int unsigned DW = 16;
endpackage

// File: rtl/sysarr_output_deskew.sv
// Bottom-row drain: deskews column results into aligned rows, buffers them in a FWFT FIFO, raises array stall.
// Optional SYSARR_OUT_RELU_EN: elements with the sign bit set are stored as zero on FIFO write.
module sysarr_output_deskew #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = sys_arr_pkg::DW,
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            nRST,
  input  logic            flush,
  input  logic [N-1:0]    col_valid,
  input  logic [N*DW-1:0] col_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic            array_stall,
  output logic            skew_err,
  output logic            ovf_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(N + 1);
  localparam int unsigned SW = ((CW > PW) ? CW : PW) + 1;
  localparam int unsigned RW = N * DW;

  // Skew pipeline: column j enters at stage j and leaves at stage N-1 (N-j registers).
  logic [N-1:0]  stg_vld_q [N];
  logic [N-1:0]  stg_vld_d [N];
  logic [DW-1:0] stg_dat_q [N][N];
  logic [DW-1:0] stg_dat_d [N][N];

  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          skew_err_q, skew_err_d;
  logic          ovf_err_q, ovf_err_d;

  logic [N-1:0]  alg_vld;
  logic [RW-1:0] wr_row;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          skew_hit;
  logic          ovf_hit;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        stg_vld_d[k][j] = 1'b0;
        stg_dat_d[k][j] = '0;
        if (k == j) begin
          stg_vld_d[k][j] = col_valid[j];
          stg_dat_d[k][j] = col_data[j*DW +: DW];
        end else if (k > j) begin
          stg_vld_d[k][j] = stg_vld_q[(k > 0) ? k - 1 : 0][j];
          stg_dat_d[k][j] = stg_dat_q[(k > 0) ? k - 1 : 0][j];
        end
      end
      if (flush) begin
        stg_vld_d[k] = '0;
      end
    end
  end

  // Aligned stage: build the row word, optionally rectified.
  always_comb begin
    alg_vld = stg_vld_q[N-1];
    wr_row  = '0;
    for (int j = 0; j < N; j++) begin
      wr_row[j*DW +: DW] = stg_dat_q[N-1][j];
`ifdef SYSARR_OUT_RELU_EN
      if (stg_dat_q[N-1][j][DW-1]) begin
        wr_row[j*DW +: DW] = '0;
      end
`endif
    end
  end

  assign push     = &alg_vld;
  assign skew_hit = (|alg_vld) && !push;
  assign pop      = out_valid && out_ready;
  assign full     = (count_q == CW'(DEPTH));
  assign wr_en    = push && (!full || pop) && !flush;
  assign ovf_hit  = push && full && !pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pending_d  = pending_q + PW'(col_valid[0]) - PW'(alg_vld[0]);
    skew_err_d = skew_err_q | skew_hit;
    ovf_err_d  = ovf_err_q | ovf_hit;

    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_row;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CW'(1);
    end

    // Flush wins over any same-cycle push or pop.
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pending_d  = '0;
      skew_err_d = 1'b0;
      ovf_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      for (int k = 0; k < N; k++) begin
        stg_vld_q[k] <= '0;
        for (int j = 0; j < N; j++) begin
          stg_dat_q[k][j] <= '0;
        end
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      skew_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      stg_vld_q  <= stg_vld_d;
      stg_dat_q  <= stg_dat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      skew_err_q <= skew_err_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  // Row storage is never read before written, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign array_stall = (SW'(count_q) + SW'(pending_q)) >= SW'(DEPTH - 1);
  assign skew_err    = skew_err_q;
  assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_sysarr_output_deskew.sv
// Directed bench for sysarr_output_deskew; expected rows go into a queue checked by a negedge monitor.
`timescale 1ns/1ps
module tb_sysarr_output_deskew;
  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned RW    = N * DW;

  logic          clk = 1'b0;
  logic          nRST;
  logic          flush;
  logic [N-1:0]  col_valid;
  logic [RW-1:0] col_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic          array_stall;
  logic          skew_err;
  logic          ovf_err;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];
  logic          hv [N];
  logic [RW-1:0] hr [N];
  logic [RW-1:0] mon_exp;

  always #5 clk = ~clk;

  sysarr_output_deskew #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .flush      (flush),
    .col_valid  (col_valid),
    .col_data   (col_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .array_stall(array_stall),
    .skew_err   (skew_err),
    .ovf_err    (ovf_err)
  );

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input logic [15:0] base);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  // One clock: column 0 takes the new launch, column j replays the row launched j cycles earlier.
  task automatic step(input logic l0, input logic [RW-1:0] row);
    for (int j = 0; j < N; j++) begin
      if (j == 0) begin
        col_valid[0]     = l0;
        col_data[DW-1:0] = l0 ? row[DW-1:0] : '0;
      end else begin
        col_valid[j]         = hv[(j > 0) ? j - 1 : 0];
        col_data[j*DW +: DW] = hv[(j > 0) ? j - 1 : 0] ? hr[(j > 0) ? j - 1 : 0][j*DW +: DW] : '0;
      end
    end
    for (int k = N - 1; k > 0; k--) begin
      hv[k] = hv[k-1];
      hr[k] = hr[k-1];
    end
    hv[0] = l0;
    hr[0] = row;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hist();
    for (int k = 0; k < N; k++) begin
      hv[k] = 1'b0;
      hr[k] = '0;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step(1'b0, '0);
    flush = 1'b0;
    exp_q.delete();
    clear_hist();
  endtask

  task automatic raw(input logic [N-1:0] cv);
    col_valid = cv;
    col_data  = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head word must match the oldest expected row.
  always @(negedge clk) begin
    if (nRST && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_row: got 0x%0h expected no row", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("row_data", out_data, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] r;
    logic [RW-1:0] row1;
    logic [RW-1:0] head1;
    int launched;

    nRST      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    col_valid = '0;
    col_data  = '0;
    clear_hist();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", RW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_array_stall", RW'(array_stall), '0);
    chk("rst_skew_err", RW'(skew_err), '0);
    chk("rst_ovf_err", RW'(ovf_err), '0);
    nRST = 1'b1;
    step(1'b0, '0);

    // Single row: latency N edges, aligned word.
    out_ready = 1'b1;
    row1 = 64'h0044_0033_0022_0011;
    exp_q.push_back(row1);
    step(1'b1, row1);
    repeat (N - 1) step(1'b0, '0);
    chk("latency_early", RW'(out_valid), '0);
    step(1'b0, '0);
    chk("latency_valid", RW'(out_valid), 64'd1);
    chk("single_row", out_data, 64'h0044_0033_0022_0011);
    chk("single_skew", RW'(skew_err), '0);
    repeat (3) step(1'b0, '0);
    chk("single_drained", RW'(out_valid), '0);

    // Ten rows offered with consumer blocked; upstream obeys stall.
    out_ready = 1'b0;
    launched  = 0;
    for (int c = 0; c < 20; c++) begin
      if (launched < 10 && !array_stall) begin
        r = mkrow(16'h1000 + 16'(launched * 16));
        exp_q.push_back(r);
        step(1'b1, r);
        launched++;
      end else begin
        step(1'b0, '0);
      end
    end
    chk("stall_launched", RW'(launched), 64'd7);
    chk("stall_high", RW'(array_stall), 64'd1);
    chk("stall_ovf", RW'(ovf_err), '0);
    chk("stall_head", out_data, 64'h1003_1002_1001_1000);
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (launched < 10 && !array_stall) begin
        r = mkrow(16'h1000 + 16'(launched * 16));
        exp_q.push_back(r);
        step(1'b1, r);
        launched++;
      end else begin
        step(1'b0, '0);
      end
    end
    chk("stall_total", RW'(launched), 64'd10);
    chk("stall_empty", RW'(exp_q.size()), '0);
    chk("stall_release", RW'(array_stall), '0);

    // Fill to DEPTH, then push and pop in the same cycle, then overflow.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      r = mkrow(16'h2000 + 16'(i * 16));
      exp_q.push_back(r);
      step(1'b1, r);
    end
    repeat (3) step(1'b0, '0);
    chk("full_head", out_data, 64'h2003_2002_2001_2000);
    out_ready = 1'b1;
    step(1'b0, '0);
    out_ready = 1'b0;
    head1 = 64'h2013_2012_2011_2010;
    chk("fullpp_head", out_data, head1);
    chk("fullpp_ovf", RW'(ovf_err), '0);
    step(1'b1, mkrow(16'h2F00));
    repeat (4) step(1'b0, '0);
    chk("ovf_set", RW'(ovf_err), 64'd1);
    chk("ovf_head_kept", out_data, head1);
    out_ready = 1'b1;
    repeat (12) step(1'b0, '0);
    chk("ovf_drained", RW'(out_valid), '0);
    chk("ovf_sb_empty", RW'(exp_q.size()), '0);
    chk("ovf_sticky", RW'(ovf_err), 64'd1);
    do_flush();
    chk("ovf_flushed", RW'(ovf_err), '0);

    // Column 2 arrives one cycle late.
    raw(4'b0001);
    raw(4'b0010);
    raw(4'b0000);
    raw(4'b1100);
    chk("skew_not_yet", RW'(skew_err), '0);
    raw(4'b0000);
    chk("skew_set", RW'(skew_err), 64'd1);
    repeat (5) raw(4'b0000);
    chk("skew_sticky", RW'(skew_err), 64'd1);
    chk("skew_no_push", RW'(out_valid), '0);
    chk("skew_pending_clr", RW'(array_stall), '0);
    do_flush();
    chk("skew_flushed", RW'(skew_err), '0);

    // Flush with 3 rows buffered and 2 in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r = mkrow(16'h3000 + 16'(i * 16));
      exp_q.push_back(r);
      step(1'b1, r);
    end
    repeat (2) step(1'b0, '0);
    chk("preflush_head", out_data, 64'h3003_3002_3001_3000);
    do_flush();
    chk("flush_valid", RW'(out_valid), '0);
    chk("flush_stall", RW'(array_stall), '0);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, '0);
      chk("flush_no_late", RW'(out_valid), '0);
    end

    // Sign-bit boundary values.
    r = {16'h7FFF, 16'h8001, 16'h0000, 16'hFFFF};
`ifdef SYSARR_OUT_RELU_EN
    exp_q.push_back({16'h7FFF, 16'h0000, 16'h0000, 16'h0000});
`else
    exp_q.push_back({16'h7FFF, 16'h8001, 16'h0000, 16'hFFFF});
`endif
    step(1'b1, r);
    repeat (N + 3) step(1'b0, '0);
    chk("sign_drained", RW'(out_valid), '0);
    chk("final_sb_empty", RW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
